sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023: max cycles BUSY waits for s_ready before aborting; legal range 1..65535.
REQ-002 Parameter FIXED_PRIO, default 0: 0 = round-robin between requesters, 1 = m0 always wins ties.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 mN_valid  in  1  requester N (N=0,1) access request; held until mN_ready.
REQ-007 mN_addr  in  32  requester N byte address.
REQ-008 mN_wdata  in  32  requester N write data.
REQ-009 mN_wstrb  in  4  requester N byte write strobes; 0 = read.
REQ-010 mN_ready  out  1  one-cycle completion pulse to requester N.
REQ-011 mN_rdata  out  32  read data to requester N, valid only while mN_ready=1.
REQ-012 mN_fault  out  1  asserted with mN_ready when the access timed out.
REQ-013 s_valid  out  1  request to SDRAM controller.
REQ-014 s_addr / s_wdata / s_wstrb  out  32/32/4  latched request fields to the controller.
REQ-015 s_ready  in  1  controller completion, one-cycle pulse.
REQ-016 s_rdata  in  32  controller read data, valid while s_ready=1.

Function
REQ-017 FSM states IDLE, BUSY, DONE; the arbiter SHALL keep exactly one access outstanding.
REQ-018 IDLE: if any mN_valid, select a grant, latch its addr/wdata/wstrb into s_* registers, clear the timeout counter, and go to BUSY on the next edge.
REQ-019 Grant: with one requester valid, grant it; with both valid and FIXED_PRIO=0, grant the requester not in last_grant; with FIXED_PRIO=1, grant m0.
REQ-020 last_grant SHALL update on entering BUSY, and only then.
REQ-021 BUSY: s_valid=1 (decoded from state, glitch-free); the counter increments each cycle.
REQ-022 BUSY with s_ready=1: capture s_rdata into the return register, fault=0, go to DONE; s_valid SHALL be 0 from the next cycle.
REQ-023 BUSY with counter==TIMEOUT_CYCLES-1 and s_ready=0: return data 32'hFFFF_FFFF, fault=1, go to DONE.
REQ-024 If s_ready and timeout coincide, s_ready wins (normal completion, fault=0).
REQ-025 DONE: assert mG_ready=1 for the granted requester for exactly one cycle, with mG_rdata/mG_fault from the return register; go to IDLE.
REQ-026 The non-granted requester's mN_ready, mN_fault SHALL be 0 and mN_rdata 0 at all times.
REQ-027 s_ready in IDLE or DONE (late response after timeout) SHALL be ignored, with no state change.
REQ-028 Latency: mN_valid sampled in IDLE at edge T gives s_valid from T+1; s_ready sampled at edge T+k gives mN_ready high during cycle T+k+1; minimum request-to-ready is 3 cycles.
REQ-029 A requester deasserting mN_valid while granted SHALL NOT abort the access; completion is still signalled.
REQ-030 The arbiter SHALL return to IDLE before re-arbitrating, so back-to-back accesses have at least 1 IDLE cycle between mN_ready and the next s_valid.
REQ-031 Changes to mN_addr/wdata/wstrb after grant SHALL NOT affect s_* outputs.
REQ-032 The counter width SHALL be 16 bits, saturating; no wrap-around in BUSY.

Reset
REQ-033 rst=1 SHALL immediately force: state=IDLE, s_valid=0, all mN_ready=0, all mN_fault=0, all rdata=0, s_addr/s_wdata=0, s_wstrb=0, counter=0, last_grant=1 (m0 wins the first tie).
REQ-034 rst asserted in BUSY or DONE SHALL abort the access with no ready pulse to any requester; after release the arbiter starts in IDLE.

Verification
REQ-035 m0 read of 0x2000_0010, s_ready after 4 BUSY cycles with s_rdata=0xDEADBEEF -> m0_ready single pulse, m0_rdata=0xDEADBEEF, m0_fault=0, m1_ready=0.
REQ-036 Both valid from reset, FIXED_PRIO=0, continuous requests -> grants alternate m0,m1,m0,m1; with FIXED_PRIO=1 -> m0 only while m0_valid held.
REQ-037 TIMEOUT_CYCLES=8, s_ready never asserted -> s_valid high exactly 8 cycles, then m1_ready=1, m1_fault=1, m1_rdata=0xFFFFFFFF; a later s_ready pulse is ignored.
REQ-038 m1 write addr 0x2000_0100, wstrb=4'b0011; m1_addr changed during BUSY -> s_addr stays 0x2000_0100 and s_wstrb stays 4'b0011 until completion.
REQ-039 rst pulsed mid-BUSY -> s_valid drops without a clock edge, no mN_ready pulse, next tie granted to m0.
REQ-040 s_ready on the same cycle the counter hits its limit -> m0_fault=0 and m0_rdata=s_rdata.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Two-requester arbiter in front of a single-outstanding SDRAM controller port.
// Latches one request, waits for completion or timeout, then pulses ready to the winner.
module sdram_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter bit          FIXED_PRIO     = 1'b0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_valid_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [3:0]  m0_wstrb_i,
    output logic        m0_ready_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_fault_o,

    input  logic        m1_valid_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [3:0]  m1_wstrb_i,
    output logic        m1_ready_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_fault_o,

    output logic        s_valid_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    output logic [3:0]  s_wstrb_o,
    input  logic        s_ready_i,
    input  logic [31:0] s_rdata_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    logic [1:0]  state_q,     state_d;
    logic        grant_q,     grant_d;
    logic        lastGrant_q, lastGrant_d;
    logic [15:0] cnt_q,       cnt_d;
    logic [31:0] sAddr_q,     sAddr_d;
    logic [31:0] sWdata_q,    sWdata_d;
    logic [3:0]  sWstrb_q,    sWstrb_d;
    logic [31:0] ret_q,       ret_d;
    logic        fault_q,     fault_d;

    logic        anyValid;
    logic        grantSel;

    assign anyValid = m0_valid_i | m1_valid_i;

    // Grant index: 0 = m0, 1 = m1. A tie goes to whoever did not win last time.
    always_comb begin
        grantSel = 1'b0;
        if (m0_valid_i && m1_valid_i) begin
            grantSel = FIXED_PRIO ? 1'b0 : ~lastGrant_q;
        end else if (m1_valid_i) begin
            grantSel = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        cnt_d       = cnt_q;
        sAddr_d     = sAddr_q;
        sWdata_d    = sWdata_q;
        sWstrb_d    = sWstrb_q;
        ret_d       = ret_q;
        fault_d     = fault_q;

        case (state_q)
            IDLE: begin
                if (anyValid) begin
                    state_d     = BUSY;
                    grant_d     = grantSel;
                    lastGrant_d = grantSel;
                    cnt_d       = 16'd0;
                    sAddr_d     = grantSel ? m1_addr_i  : m0_addr_i;
                    sWdata_d    = grantSel ? m1_wdata_i : m0_wdata_i;
                    sWstrb_d    = grantSel ? m1_wstrb_i : m0_wstrb_i;
                end
            end
            BUSY: begin
                cnt_d = (cnt_q != CNT_MAX) ? cnt_q + 16'd1 : cnt_q;
                // A completion arriving on the timeout cycle still counts as a good access.
                if (s_ready_i) begin
                    state_d = DONE;
                    ret_d   = s_rdata_i;
                    fault_d = 1'b0;
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d = DONE;
                    ret_d   = 32'hFFFF_FFFF;
                    fault_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            lastGrant_q <= 1'b1;
            cnt_q       <= 16'd0;
            sAddr_q     <= 32'd0;
            sWdata_q    <= 32'd0;
            sWstrb_q    <= 4'd0;
            ret_q       <= 32'd0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
            cnt_q       <= cnt_d;
            sAddr_q     <= sAddr_d;
            sWdata_q    <= sWdata_d;
            sWstrb_q    <= sWstrb_d;
            ret_q       <= ret_d;
            fault_q     <= fault_d;
        end
    end

    // Outputs decode straight from registered state, so reset clears them without a clock.
    assign s_valid_o  = (state_q == BUSY);
    assign s_addr_o   = sAddr_q;
    assign s_wdata_o  = sWdata_q;
    assign s_wstrb_o  = sWstrb_q;

    assign m0_ready_o = (state_q == DONE) && !grant_q;
    assign m1_ready_o = (state_q == DONE) &&  grant_q;
    assign m0_rdata_o = m0_ready_o ? ret_q : 32'd0;
    assign m1_rdata_o = m1_ready_o ? ret_q : 32'd0;
    assign m0_fault_o = m0_ready_o & fault_q;
    assign m1_fault_o = m1_ready_o & fault_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: round-robin instance A and fixed-priority instance B
// share all stimulus; both use an 8-cycle timeout.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0Valid = 1'b0, m1Valid = 1'b0;
    logic [31:0] m0Addr = '0, m0Wdata = '0, m1Addr = '0, m1Wdata = '0;
    logic [3:0]  m0Wstrb = '0, m1Wstrb = '0;
    logic        sReady = 1'b0;
    logic [31:0] sRdata = '0;

    logic        aM0Ready, aM0Fault, aM1Ready, aM1Fault, aSValid;
    logic [31:0] aM0Rdata, aM1Rdata, aSAddr, aSWdata;
    logic [3:0]  aSWstrb;
    logic        bM0Ready, bM0Fault, bM1Ready, bM1Fault, bSValid;
    logic [31:0] bM0Rdata, bM1Rdata, bSAddr, bSWdata;
    logic [3:0]  bSWstrb;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(.TIMEOUT_CYCLES(8), .FIXED_PRIO(1'b0)) dutA (
        .clk(clk), .rst(rst),
        .m0_valid_i(m0Valid), .m0_addr_i(m0Addr), .m0_wdata_i(m0Wdata), .m0_wstrb_i(m0Wstrb),
        .m0_ready_o(aM0Ready), .m0_rdata_o(aM0Rdata), .m0_fault_o(aM0Fault),
        .m1_valid_i(m1Valid), .m1_addr_i(m1Addr), .m1_wdata_i(m1Wdata), .m1_wstrb_i(m1Wstrb),
        .m1_ready_o(aM1Ready), .m1_rdata_o(aM1Rdata), .m1_fault_o(aM1Fault),
        .s_valid_o(aSValid), .s_addr_o(aSAddr), .s_wdata_o(aSWdata), .s_wstrb_o(aSWstrb),
        .s_ready_i(sReady), .s_rdata_i(sRdata)
    );

    sdram_arbiter #(.TIMEOUT_CYCLES(8), .FIXED_PRIO(1'b1)) dutB (
        .clk(clk), .rst(rst),
        .m0_valid_i(m0Valid), .m0_addr_i(m0Addr), .m0_wdata_i(m0Wdata), .m0_wstrb_i(m0Wstrb),
        .m0_ready_o(bM0Ready), .m0_rdata_o(bM0Rdata), .m0_fault_o(bM0Fault),
        .m1_valid_i(m1Valid), .m1_addr_i(m1Addr), .m1_wdata_i(m1Wdata), .m1_wstrb_i(m1Wstrb),
        .m1_ready_o(bM1Ready), .m1_rdata_o(bM1Rdata), .m1_fault_o(bM1Fault),
        .s_valid_o(bSValid), .s_addr_o(bSAddr), .s_wdata_o(bSWdata), .s_wstrb_o(bSWstrb),
        .s_ready_i(sReady), .s_rdata_i(sRdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({aSValid, aM0Ready, aM1Ready, aM0Fault, aM1Fault} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got %b want 00000", {aSValid, aM0Ready, aM1Ready, aM0Fault, aM1Fault});
        end
        vectors++;
        if ({aSAddr, aSWdata, aSWstrb, aM0Rdata, aM1Rdata} !== 132'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got %h want 0", {aSAddr, aSWdata, aSWstrb, aM0Rdata, aM1Rdata});
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_arbitration();
        logic [3:0] expA;
        expA = 4'b1010;
        m0Valid = 1'b1; m0Addr = 32'h1000_0000;
        m1Valid = 1'b1; m1Addr = 32'h1000_0004;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (aSValid !== 1'b1 || bSValid !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL arb_svalid[%0d]: got A=%b B=%b want 1 1", i, aSValid, bSValid);
            end
            sReady = 1'b1; sRdata = 32'h0000_1000 + i;
            tick();
            sReady = 1'b0;
            vectors++;
            if ({aM1Ready, aM0Ready} !== {expA[i], ~expA[i]}) begin
                miscompares++;
                $display("[TB] FAIL arb_rr_grant[%0d]: got m1,m0=%b%b want %b%b", i, aM1Ready, aM0Ready, expA[i], ~expA[i]);
            end
            vectors++;
            if ({bM1Ready, bM0Ready} !== 2'b01) begin
                miscompares++;
                $display("[TB] FAIL arb_fixed_grant[%0d]: got m1,m0=%b%b want 01", i, bM1Ready, bM0Ready);
            end
            vectors++;
            if ((expA[i] ? aM1Rdata : aM0Rdata) !== 32'h0000_1000 + i) begin
                miscompares++;
                $display("[TB] FAIL arb_rdata[%0d]: got %h want %h", i, expA[i] ? aM1Rdata : aM0Rdata, 32'h0000_1000 + i);
            end
            tick();
            vectors++;
            if (aSValid !== 1'b0 || aM0Ready !== 1'b0 || aM1Ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL arb_idle_gap[%0d]: got sv=%b r0=%b r1=%b want 0 0 0", i, aSValid, aM0Ready, aM1Ready);
            end
        end
        m0Valid = 1'b0; m1Valid = 1'b0;
        tick();
    endtask

    task automatic test_read();
        m0Valid = 1'b1; m0Addr = 32'h2000_0010; m0Wstrb = 4'b0000;
        tick();
        vectors++;
        if (aSValid !== 1'b1 || aSAddr !== 32'h2000_0010 || aSWstrb !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL read_issue: got sv=%b addr=%h strb=%b want 1 20000010 0000", aSValid, aSAddr, aSWstrb);
        end
        tick(); tick(); tick();
        sReady = 1'b1; sRdata = 32'hDEAD_BEEF;
        tick();
        sReady = 1'b0; m0Valid = 1'b0;
        vectors++;
        if ({aM0Ready, aM0Fault, aM1Ready, aSValid} !== 4'b1000 || aM0Rdata !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("[TB] FAIL read_done: got r0=%b f0=%b r1=%b sv=%b rdata=%h want 1 0 0 0 deadbeef",
                     aM0Ready, aM0Fault, aM1Ready, aSValid, aM0Rdata);
        end
        vectors++;
        if (aM1Rdata !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL read_other_rdata: got %h want 0", aM1Rdata);
        end
        tick();
        vectors++;
        if (aM0Ready !== 1'b0 || aM0Rdata !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL read_single_pulse: got r0=%b rdata=%h want 0 0", aM0Ready, aM0Rdata);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit done;
        n = 0; done = 1'b0;
        m1Valid = 1'b1; m1Addr = 32'h3000_0000; m1Wstrb = 4'b0000;
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            if (aM1Ready) done = 1'b1;
            else if (aSValid) n++;
        end
        m1Valid = 1'b0;
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL timeout_wait: got no m1_ready within 20 cycles want ready");
        end
        vectors++;
        if (n !== 8) begin
            miscompares++;
            $display("[TB] FAIL timeout_busy_len: got %0d want 8", n);
        end
        vectors++;
        if (aM1Fault !== 1'b1 || aM1Rdata !== 32'hFFFF_FFFF || aM0Ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout_result: got f1=%b rdata=%h r0=%b want 1 ffffffff 0", aM1Fault, aM1Rdata, aM0Ready);
        end
        tick();
        sReady = 1'b1; sRdata = 32'h1234_5678;
        tick();
        sReady = 1'b0;
        vectors++;
        if ({aSValid, aM0Ready, aM1Ready} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL timeout_late_ready: got sv=%b r0=%b r1=%b want 0 0 0", aSValid, aM0Ready, aM1Ready);
        end
        tick();
        vectors++;
        if ({aSValid, aM0Ready, aM1Ready} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL timeout_late_after: got sv=%b r0=%b r1=%b want 0 0 0", aSValid, aM0Ready, aM1Ready);
        end
    endtask

    task automatic test_write_hold();
        m1Valid = 1'b1; m1Addr = 32'h2000_0100; m1Wdata = 32'hCAFE_F00D; m1Wstrb = 4'b0011;
        tick();
        vectors++;
        if (aSAddr !== 32'h2000_0100 || aSWdata !== 32'hCAFE_F00D || aSWstrb !== 4'b0011) begin
            miscompares++;
            $display("[TB] FAIL write_issue: got addr=%h wdata=%h strb=%b want 20000100 cafef00d 0011", aSAddr, aSWdata, aSWstrb);
        end
        m1Valid = 1'b0; m1Addr = 32'hFFFF_0000; m1Wdata = 32'h0BAD_0BAD; m1Wstrb = 4'b1100;
        tick(); tick();
        vectors++;
        if (aSValid !== 1'b1 || aSAddr !== 32'h2000_0100 || aSWstrb !== 4'b0011 || aSWdata !== 32'hCAFE_F00D) begin
            miscompares++;
            $display("[TB] FAIL write_hold: got sv=%b addr=%h strb=%b wdata=%h want 1 20000100 0011 cafef00d",
                     aSValid, aSAddr, aSWstrb, aSWdata);
        end
        sReady = 1'b1; sRdata = 32'd0;
        tick();
        sReady = 1'b0;
        vectors++;
        if (aM1Ready !== 1'b1 || aM1Fault !== 1'b0 || aM0Ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL write_done: got r1=%b f1=%b r0=%b want 1 0 0", aM1Ready, aM1Fault, aM0Ready);
        end
        tick();
    endtask

    task automatic test_coincide();
        m0Valid = 1'b1; m0Addr = 32'h2000_0020; m0Wstrb = 4'b0000;
        for (int k = 0; k < 8; k++) tick();
        vectors++;
        if (aSValid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL coincide_busy: got sv=%b want 1", aSValid);
        end
        sReady = 1'b1; sRdata = 32'h5A5A_A5A5;
        tick();
        sReady = 1'b0; m0Valid = 1'b0;
        vectors++;
        if (aM0Ready !== 1'b1 || aM0Fault !== 1'b0 || aM0Rdata !== 32'h5A5A_A5A5) begin
            miscompares++;
            $display("[TB] FAIL coincide_result: got r0=%b f0=%b rdata=%h want 1 0 5a5aa5a5", aM0Ready, aM0Fault, aM0Rdata);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        bit sawReady;
        sawReady = 1'b0;
        m0Valid = 1'b1; m0Addr = 32'h2000_0030;
        tick(); tick();
        vectors++;
        if (aSValid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL abort_busy: got sv=%b want 1", aSValid);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (aSValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_async: got sv=%b want 0", aSValid);
        end
        m0Valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (aM0Ready || aM1Ready) sawReady = 1'b1;
        end
        rst = 1'b0;
        tick();
        if (aM0Ready || aM1Ready) sawReady = 1'b1;
        vectors++;
        if (sawReady !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_no_ready: got pulse want none");
        end
        m0Valid = 1'b1; m1Valid = 1'b1;
        tick();
        sReady = 1'b1; sRdata = 32'h0000_0077;
        tick();
        sReady = 1'b0; m0Valid = 1'b0; m1Valid = 1'b0;
        vectors++;
        if ({aM1Ready, aM0Ready} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL abort_tie_after_reset: got m1,m0=%b%b want 01", aM1Ready, aM0Ready);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_read();
        test_timeout();
        test_write_hold();
        test_coincide();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
